nrisc_ula_wb: RTL and testbench

NRISC_ULA_WB -- requirements
Module: nrisc_ula_wb

---
 rtl/nrisc_pkg.sv | 20 ++
 rtl/nrisc_wb_fifo2.sv | 117 +++++++++++
 rtl/nrisc_ula_wb.sv | 86 ++++++++
 tb/tb_nrisc_ula_wb.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_pkg.sv
// Shared NRISC definitions: ALU flag layout and default datapath width,
// used by both the ALU (NRISC_ULA) and its write-back stage (nrisc_ula_wb).
package nrisc_pkg;

    localparam int NRISC_TAM = 16;

    localparam int FLAG_W = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    typedef logic [FLAG_W-1:0] flags_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_count_e;

endpackage

// File: rtl/nrisc_wb_fifo2.sv
// Two-entry in-order buffer of ALU results awaiting write-back.
// With NRISC_WB_FWD_EN defined it also exposes the youngest buffered register write.
module nrisc_wb_fifo2
    import nrisc_pkg::*;
#(
    parameter int TAM  = NRISC_TAM,
    parameter int RA_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [TAM-1:0]  push_result_i,
    input  flags_t          push_flags_i,
    input  logic [RA_W-1:0] push_rd_i,
    input  logic            push_wr_en_i,
    input  logic            push_flag_en_i,
    input  logic            pop_i,
    output logic            not_full_o,
    output logic            head_valid_o,
    output logic [TAM-1:0]  head_result_o,
    output flags_t          head_flags_o,
    output logic [RA_W-1:0] head_rd_o,
    output logic            head_wr_en_o,
    output logic            head_flag_en_o
`ifdef NRISC_WB_FWD_EN
    ,
    output logic            fwd_valid_o,
    output logic [RA_W-1:0] fwd_rd_o,
    output logic [TAM-1:0]  fwd_data_o
`endif
);

    logic [TAM-1:0]  result_q  [2];
    flags_t          flags_q   [2];
    logic [RA_W-1:0] rd_q      [2];
    logic            wrEn_q    [2];
    logic            flagEn_q  [2];

    fifo_count_e count_q, count_d;
    logic        rptr_q, rptr_d;
    logic        wptr_q, wptr_d;
    logic        doPush, doPop;

    // Flush wins over a same-cycle push; a pop that cycle still counts so the
    // caller can commit the retiring head's flags.
    always_comb begin
        doPush  = push_i && (count_q != FIFO_FULL) && !flush_i;
        doPop   = pop_i && (count_q != FIFO_EMPTY);
        count_d = count_q;
        rptr_d  = rptr_q ^ doPop;
        wptr_d  = wptr_q ^ doPush;
        if (flush_i) begin
            count_d = FIFO_EMPTY;
            rptr_d  = 1'b0;
            wptr_d  = 1'b0;
        end else if (doPush && !doPop) begin
            count_d = (count_q == FIFO_EMPTY) ? FIFO_ONE : FIFO_FULL;
        end else if (doPop && !doPush) begin
            count_d = (count_q == FIFO_FULL) ? FIFO_ONE : FIFO_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= FIFO_EMPTY;
            rptr_q  <= 1'b0;
            wptr_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
        end
    end

    // Payload needs no reset: it is only observed through a nonzero count.
    always_ff @(posedge clk) begin
        if (doPush) begin
            result_q[wptr_q] <= push_result_i;
            flags_q[wptr_q]  <= push_flags_i;
            rd_q[wptr_q]     <= push_rd_i;
            wrEn_q[wptr_q]   <= push_wr_en_i;
            flagEn_q[wptr_q] <= push_flag_en_i;
        end
    end

    assign not_full_o     = (count_q != FIFO_FULL);
    assign head_valid_o   = (count_q != FIFO_EMPTY);
    assign head_result_o  = result_q[rptr_q];
    assign head_flags_o   = flags_q[rptr_q];
    assign head_rd_o      = rd_q[rptr_q];
    assign head_wr_en_o   = wrEn_q[rptr_q];
    assign head_flag_en_o = flagEn_q[rptr_q];

`ifdef NRISC_WB_FWD_EN
    logic youngIdx;

    // The youngest entry sits just behind the write pointer; when full and it
    // carries no register write, fall back to the older head entry.
    always_comb begin
        youngIdx    = ~wptr_q;
        fwd_valid_o = 1'b0;
        fwd_rd_o    = '0;
        fwd_data_o  = '0;
        if ((count_q != FIFO_EMPTY) && wrEn_q[youngIdx]) begin
            fwd_valid_o = 1'b1;
            fwd_rd_o    = rd_q[youngIdx];
            fwd_data_o  = result_q[youngIdx];
        end else if ((count_q == FIFO_FULL) && wrEn_q[rptr_q]) begin
            fwd_valid_o = 1'b1;
            fwd_rd_o    = rd_q[rptr_q];
            fwd_data_o  = result_q[rptr_q];
        end
    end
`endif

endmodule

// File: rtl/nrisc_ula_wb.sv
// NRISC ALU write-back stage: buffers results, writes the register file, updates {N,Z,C}.
// Optional macro NRISC_WB_FWD_EN adds fwd_valid/fwd_rd/fwd_data forwarding outputs.
module nrisc_ula_wb
    import nrisc_pkg::*;
#(
    parameter int TAM  = NRISC_TAM,
    parameter int RA_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [TAM-1:0]  in_result,
    input  flags_t          in_flags,
    input  logic [RA_W-1:0] in_rd,
    input  logic            in_wr_en,
    input  logic            in_flag_en,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [TAM-1:0]  out_data,
    output logic [RA_W-1:0] out_rd,
    output flags_t          status_q
`ifdef NRISC_WB_FWD_EN
    ,
    output logic            fwd_valid,
    output logic [RA_W-1:0] fwd_rd,
    output logic [TAM-1:0]  fwd_data
`endif
);

    logic   headValid;
    logic   headWrEn;
    logic   headFlagEn;
    flags_t headFlags;
    logic   retire;
    flags_t status_d;

    nrisc_wb_fifo2 #(
        .TAM  (TAM),
        .RA_W (RA_W)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush),
        .push_i         (in_valid),
        .push_result_i  (in_result),
        .push_flags_i   (in_flags),
        .push_rd_i      (in_rd),
        .push_wr_en_i   (in_wr_en),
        .push_flag_en_i (in_flag_en),
        .pop_i          (retire),
        .not_full_o     (in_ready),
        .head_valid_o   (headValid),
        .head_result_o  (out_data),
        .head_flags_o   (headFlags),
        .head_rd_o      (out_rd),
        .head_wr_en_o   (headWrEn),
        .head_flag_en_o (headFlagEn)
`ifdef NRISC_WB_FWD_EN
        ,
        .fwd_valid_o    (fwd_valid),
        .fwd_rd_o       (fwd_rd),
        .fwd_data_o     (fwd_data)
`endif
    );

    // Entries without a register write never wait on the register file.
    always_comb begin
        out_valid = headValid && headWrEn;
        retire    = headValid && (!headWrEn || out_ready);
        status_d  = status_q;
        if (retire && headFlagEn) begin
            status_d = headFlags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

endmodule

// File: tb/tb_nrisc_ula_wb.sv
// Directed self-checking bench for nrisc_ula_wb; define NRISC_WB_FWD_EN to also
// exercise the forwarding outputs.
module tb_nrisc_ula_wb;

    localparam int TAM  = 16;
    localparam int RA_W = 4;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [TAM-1:0]  in_result;
    logic [2:0]      in_flags;
    logic [RA_W-1:0] in_rd;
    logic            in_wr_en;
    logic            in_flag_en;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [TAM-1:0]  out_data;
    logic [RA_W-1:0] out_rd;
    logic [2:0]      status_q;
`ifdef NRISC_WB_FWD_EN
    logic            fwd_valid;
    logic [RA_W-1:0] fwd_rd;
    logic [TAM-1:0]  fwd_data;
`endif

    int vectors;
    int miscompares;

    nrisc_ula_wb #(
        .TAM  (TAM),
        .RA_W (RA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_flags   (in_flags),
        .in_rd      (in_rd),
        .in_wr_en   (in_wr_en),
        .in_flag_en (in_flag_en),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .status_q   (status_q)
`ifdef NRISC_WB_FWD_EN
        ,
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle 1 time unit so outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [TAM-1:0] res, input logic [2:0] fl,
                                 input logic [RA_W-1:0] rd, input logic wr, input logic fe);
        in_valid   = v;
        in_result  = res;
        in_flags   = fl;
        in_rd      = rd;
        in_wr_en   = wr;
        in_flag_en = fe;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        flush       = 1'b0;
        out_ready   = 1'b0;
        applyStimulus(1'b0, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0);

        // Reset state
        tick();
        tick();
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_status", {29'd0, status_q}, 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single write with flags, one-cycle latency, retire
        out_ready = 1'b1;
        applyStimulus(1'b1, 16'h0005, 3'b000, 4'd3, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0);
        checkOutput("w1_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("w1_out_data", {16'd0, out_data}, 32'h0005);
        checkOutput("w1_out_rd", {28'd0, out_rd}, 32'd3);
        tick();
        checkOutput("w1_retired", {31'd0, out_valid}, 32'd0);
        checkOutput("w1_status", {29'd0, status_q}, 32'd0);

        applyStimulus(1'b1, 16'hABCD, 3'b101, 4'd7, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0);
        checkOutput("w2_out_rd", {28'd0, out_rd}, 32'd7);
        tick();
        checkOutput("w2_status", {29'd0, status_q}, 32'b101);

        // Backpressure: three pushes with out_ready low, order preserved
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h1111, 3'b111, 4'd1, 1'b1, 1'b0);
        tick();
        checkOutput("bp_ready_after1", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b1, 16'h2222, 3'b111, 4'd2, 1'b1, 1'b0);
        tick();
        checkOutput("bp_ready_after2", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b1, 16'h3333, 3'b111, 4'd4, 1'b1, 1'b0);
        tick();
        checkOutput("bp_still_full", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_head_a", {16'd0, out_data}, 32'h1111);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_head_b", {16'd0, out_data}, 32'h2222);
        checkOutput("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0);
        checkOutput("bp_head_c_data", {16'd0, out_data}, 32'h3333);
        checkOutput("bp_head_c_rd", {28'd0, out_rd}, 32'd4);
        checkOutput("bp_head_c_valid", {31'd0, out_valid}, 32'd1);
        tick();
        checkOutput("bp_drained", {31'd0, out_valid}, 32'd0);
        checkOutput("bp_status_hold", {29'd0, status_q}, 32'b101);

        // Flag-only entry retires regardless of out_ready
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'hFFFF, 3'b010, 4'd9, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0);
        checkOutput("fo_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("fo_status_before", {29'd0, status_q}, 32'b101);
        tick();
        checkOutput("fo_status_after", {29'd0, status_q}, 32'b010);
        checkOutput("fo_in_ready", {31'd0, in_ready}, 32'd1);

        // Flush with two buffered entries: head flags still commit
        applyStimulus(1'b1, 16'h4444, 3'b100, 4'd6, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h5555, 3'b001, 4'd8, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0);
        checkOutput("fl_full", {31'd0, in_ready}, 32'd0);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        checkOutput("fl_status", {29'd0, status_q}, 32'b100);
        checkOutput("fl_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("fl_in_ready", {31'd0, in_ready}, 32'd1);

        // Flush drops a same-cycle push
        applyStimulus(1'b1, 16'h6666, 3'b000, 4'd10, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h7777, 3'b000, 4'd11, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0);
        checkOutput("fl_push_dropped", {31'd0, out_valid}, 32'd0);

        // Full-rate streaming with out_ready held high
        out_ready = 1'b1;
        applyStimulus(1'b1, 16'h0A01, 3'b000, 4'd1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0A02, 3'b000, 4'd2, 1'b1, 1'b0);
        checkOutput("st_x1", {16'd0, out_data}, 32'h0A01);
        tick();
        applyStimulus(1'b1, 16'h0A03, 3'b000, 4'd3, 1'b1, 1'b0);
        checkOutput("st_x2", {16'd0, out_data}, 32'h0A02);
        checkOutput("st_ready", {31'd0, in_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0);
        checkOutput("st_x3", {16'd0, out_data}, 32'h0A03);
        tick();
        checkOutput("st_empty", {31'd0, out_valid}, 32'd0);

`ifdef NRISC_WB_FWD_EN
        // Forwarding picks the youngest register write
        out_ready = 1'b0;
        checkOutput("fw_idle", {31'd0, fwd_valid}, 32'd0);
        applyStimulus(1'b1, 16'h1111, 3'b000, 4'd2, 1'b1, 1'b0);
        tick();
        checkOutput("fw_rd2", {28'd0, fwd_rd}, 32'd2);
        applyStimulus(1'b1, 16'h2222, 3'b000, 4'd5, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0);
        checkOutput("fw_valid", {31'd0, fwd_valid}, 32'd1);
        checkOutput("fw_rd5", {28'd0, fwd_rd}, 32'd5);
        checkOutput("fw_data", {16'd0, fwd_data}, 32'h2222);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("fw_flushed", {31'd0, fwd_valid}, 32'd0);
`endif

        // Asynchronous reset between edges with two entries buffered
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h8888, 3'b111, 4'd12, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h9999, 3'b111, 4'd13, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0000, 3'b000, 4'd0, 1'b0, 1'b0);
        checkOutput("ar_pre_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("ar_pre_status", {29'd0, status_q}, 32'b100);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("ar_status", {29'd0, status_q}, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        checkOutput("ar_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("ar_no_entries", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
